// File: rtl/div_pkg.sv
// Shared types and constants for the iterative radix-2 divider.
// The DIV_ZERO_FAST_EN macro (see div_unit) changes only timing, not anything here.
package div_pkg;

    localparam int DIV_CYCLES = 32;

    typedef logic [5:0] div_cnt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Raw encodings used by the state register; they match div_state_e.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/div_unit_if.sv
// EX-stage divider request/result bundle.
// Handshake: start_i is a level request held while the pipeline stalls; ok_o low means
// "division in flight, hold everything"; valid_o pulses for one cycle when quo_o/rem_o are fresh.
interface div_unit_if;

    logic        start_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        flush_i;
    logic        ok_o;
    logic        valid_o;
    logic [31:0] quo_o;
    logic [31:0] rem_o;

    modport master (
        output start_i, signed_i, dividend_i, divisor_i, flush_i,
        input  ok_o, valid_o, quo_o, rem_o
    );

    modport slave (
        input  start_i, signed_i, dividend_i, divisor_i, flush_i,
        output ok_o, valid_o, quo_o, rem_o
    );

endinterface

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation: absolute value on the operand side,
// sign restoration on the result side.
module div_sign_fix (
    input  logic [31:0] val,
    input  logic        neg,
    output logic [31:0] res
);

    assign res = neg ? (~val + 32'd1) : val;

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider for MIPS DIV/DIVU with IDLE/CALC/DONE FSM.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips CALC and finishes in one cycle.
module div_unit
    import div_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    div_unit_if.slave  bus,
    output div_state_e state_o
);

    logic [1:0]  state;
    div_cnt_t    cnt;
    logic [63:0] part;
    logic [31:0] dvsr;
    logic        q_neg;
    logic        r_neg;
    logic [31:0] quo_q;
    logic [31:0] rem_q;

    logic        accept;
    logic        fast_zero;
    logic        last_step;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] trial;
    logic [63:0] shifted;
    logic [63:0] step_part;
    logic [31:0] fix_q_in;
    logic [31:0] fix_r_in;
    logic        fix_q_neg;
    logic        fix_r_neg;
    logic [31:0] fix_q;
    logic [31:0] fix_r;

    assign accept    = (state == ST_IDLE) & bus.start_i & ~bus.flush_i;
    assign last_step = (state == ST_CALC) && (cnt == div_cnt_t'(DIV_CYCLES - 1));
    assign a_neg     = bus.signed_i & bus.dividend_i[31];
    assign b_neg     = bus.signed_i & bus.divisor_i[31];

`ifdef DIV_ZERO_FAST_EN
    assign fast_zero = accept & (bus.divisor_i == 32'd0);
`else
    assign fast_zero = 1'b0;
`endif

    div_sign_fix u_abs_a (.val(bus.dividend_i), .neg(a_neg), .res(abs_a));
    div_sign_fix u_abs_b (.val(bus.divisor_i),  .neg(b_neg), .res(abs_b));

    // 33-bit trial keeps the bit shifted out of the upper half, so no wrap on compare.
    assign shifted   = {part[62:0], 1'b0};
    assign trial     = part[63:31] - {1'b0, dvsr};
    assign step_part = trial[32] ? shifted : {trial[31:0], shifted[31:1], 1'b1};

    // A zero divisor yields all-ones quotient magnitude and |dividend| remainder either way.
    assign fix_q_in  = fast_zero ? 32'hFFFF_FFFF : step_part[31:0];
    assign fix_r_in  = fast_zero ? abs_a         : step_part[63:32];
    assign fix_q_neg = fast_zero ? a_neg         : q_neg;
    assign fix_r_neg = fast_zero ? a_neg         : r_neg;

    div_sign_fix u_fix_q (.val(fix_q_in), .neg(fix_q_neg), .res(fix_q));
    div_sign_fix u_fix_r (.val(fix_r_in), .neg(fix_r_neg), .res(fix_r));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
            part  <= '0;
            dvsr  <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            quo_q <= '0;
            rem_q <= '0;
        end else if (bus.flush_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        part  <= {32'd0, abs_a};
                        dvsr  <= abs_b;
                        q_neg <= a_neg ^ b_neg;
                        r_neg <= a_neg;
                        cnt   <= '0;
                        if (fast_zero) begin
                            state <= ST_DONE;
                            quo_q <= fix_q;
                            rem_q <= fix_r;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    part <= step_part;
                    cnt  <= cnt + div_cnt_t'(1);
                    if (last_step) begin
                        state <= ST_DONE;
                        quo_q <= fix_q;
                        rem_q <= fix_r;
                    end
                end
                // A start still held here belongs to the finished instruction.
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ok_o    = bus.flush_i | ~(accept | (state == ST_CALC));
    assign bus.valid_o = (state == ST_DONE) & ~bus.flush_i;
    assign bus.quo_o   = quo_q;
    assign bus.rem_o   = rem_q;
    assign state_o     = div_state_e'(state);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: constant vector table, randomized operands against
// a plain-arithmetic model, and hand sequences for hold, flush and mid-run reset.
module tb_div_unit;
    import div_pkg::*;

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    div_state_e state_dbg;
    div_unit_if bus();

    int n_checks = 0;
    int n_fail = 0;
    int valid_count = 0;
    logic [63:0] exp_q[$];
    vec_t vecs[8];

    div_unit dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus),
        .state_o (state_dbg)
    );

    // ---------------- clock / pulse monitor ----------------
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.valid_o) valid_count++;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0)
            return {((sg && a[31]) ? 32'h1 : 32'hFFFF_FFFF), a};
        if (!sg)
            return {a / b, a % b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {q[31:0], r[31:0]};
    endfunction

    function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        return (b == 32'd0) ? 1 : 33;
`else
        if (b == 32'd0) return 33;
        return 33;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver ----------------
    // Called 1 time unit after a posedge; that cycle is cycle 0 of the division.
    task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b, input bit hold,
                          output logic [31:0] q, output logic [31:0] r,
                          output int done_cyc, output int ok_low);
        q = '0;
        r = '0;
        done_cyc = -1;
        ok_low = 0;
        bus.start_i    = 1'b1;
        bus.signed_i   = sg;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!bus.ok_o) ok_low++;
            if (bus.valid_o) begin
                done_cyc = c;
                q = bus.quo_o;
                r = bus.rem_o;
            end
            step();
            if (c == 0 && !hold) bus.start_i = 1'b0;
            if (done_cyc >= 0) break;
        end
        if (!hold) bus.start_i = 1'b0;
    endtask

    task automatic run_checked(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        logic [63:0] e;
        int d, lo, vc0;
        vc0 = valid_count;
        do_div(sg, a, b, 1'b0, q, r, d, lo);
        e = exp_q.pop_front();
        check({tag, "_quo"}, {32'd0, q}, {32'd0, e[63:32]});
        check({tag, "_rem"}, {32'd0, r}, {32'd0, e[31:0]});
        check({tag, "_done_cycle"}, 64'(d), 64'(exp_lat(b)));
        check({tag, "_ok_low_cycles"}, 64'(lo), 64'(exp_lat(b)));
        check({tag, "_valid_pulses"}, 64'(valid_count - vc0), 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] q, r, a, b;
        logic        sg;
        int d, lo, vc0, k;

        bus.start_i = 1'b0; bus.signed_i = 1'b0; bus.flush_i = 1'b0;
        bus.dividend_i = '0; bus.divisor_i = '0;

        vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
        vecs[3] = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
        vecs[4] = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'd1,          32'hFFFF_FFF9};
        vecs[5] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
        vecs[6] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
        vecs[7] = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ok", {63'd0, bus.ok_o}, 64'd1);
        check("reset_valid", {63'd0, bus.valid_o}, 64'd0);
        check("reset_quo", {32'd0, bus.quo_o}, 64'd0);
        check("reset_rem", {32'd0, bus.rem_o}, 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // table vectors
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({vecs[i].q, vecs[i].r});
            run_checked($sformatf("vec%0d", i), vecs[i].sg, vecs[i].a, vecs[i].b);
        end

        // randomized operands against the model
        for (int i = 0; i < 40; i++) begin
            sg = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            k  = $urandom_range(0, 4);
            case (k)
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            exp_q.push_back(model(sg, a, b));
            run_checked($sformatf("rand%0d", i), sg, a, b);
        end

        // start held high through DONE: exactly two pulses, cycles 33 and 67
        vc0 = valid_count;
        do_div(1'b1, 32'd100, 32'd7, 1'b1, q, r, d, lo);
        check("hold1_done_cycle", 64'(d), 64'd33);
        check("hold1_quo", {32'd0, q}, 64'd14);
        do_div(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b1, q, r, d, lo);
        check("hold2_done_cycle", 64'(34 + d), 64'd67);
        check("hold2_quo", {32'd0, q}, {32'd0, 32'hFFFF_FFF2});
        check("hold2_rem", {32'd0, r}, {32'd0, 32'hFFFF_FFFE});
        bus.start_i = 1'b0;
        repeat (40) step();
        check("hold_valid_pulses", 64'(valid_count - vc0), 64'd2);

        // flush in cycle 10 of DIVU 100/7, fresh DIVU 9/3 from cycle 11
        vc0 = valid_count;
        bus.start_i = 1'b1; bus.signed_i = 1'b0;
        bus.dividend_i = 32'd100; bus.divisor_i = 32'd7;
        for (int c = 0; c < 10; c++) begin
            step();
            bus.start_i = 1'b0;
        end
        bus.flush_i = 1'b1;
        @(negedge clk);
        check("flush_ok_cycle10", {63'd0, bus.ok_o}, 64'd1);
        check("flush_valid_cycle10", {63'd0, bus.valid_o}, 64'd0);
        step();
        bus.flush_i = 1'b0;
        check("flush_idle_cycle11", 64'(state_dbg), 64'(IDLE));
        do_div(1'b0, 32'd9, 32'd3, 1'b0, q, r, d, lo);
        check("flush_restart_done_cycle", 64'(11 + d), 64'd44);
        check("flush_restart_quo", {32'd0, q}, 64'd3);
        check("flush_restart_rem", {32'd0, r}, 64'd0);
        check("flush_valid_pulses", 64'(valid_count - vc0), 64'd1);

        // reset in cycle 20 of a running division
        vc0 = valid_count;
        bus.start_i = 1'b1; bus.signed_i = 1'b0;
        bus.dividend_i = 32'd100; bus.divisor_i = 32'd7;
        for (int c = 0; c < 20; c++) begin
            step();
            bus.start_i = 1'b0;
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_ok_cycle21", {63'd0, bus.ok_o}, 64'd1);
        check("midreset_quo", {32'd0, bus.quo_o}, 64'd0);
        check("midreset_rem", {32'd0, bus.rem_o}, 64'd0);
        repeat (40) step();
        check("midreset_no_valid", 64'(valid_count - vc0), 64'd0);

        exp_q.push_back(model(1'b0, 32'd100, 32'd7));
        run_checked("post_reset", 1'b0, 32'd100, 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so a stuck bench still terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
